// File: rtl/tick_seq_pkg.sv
// Shared types and constants for the tick sequencer: FSM state encoding and
// the width of the tick counter.
package tick_seq_pkg;

    localparam int unsigned TICK_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        STEP = 2'b10,
        ZERO = 2'b11
    } state_t;

endpackage

// File: rtl/tick_sequencer_debounce.sv
// Level debouncer: the filtered output follows the raw input only after the
// raw input has differed from it for 2^DB_W consecutive cycles.
module debounce #(
    parameter int unsigned DB_W = 16
) (
    input  logic clock,
    input  logic clear_n,
    input  logic raw,
    output logic filt
);

    logic [DB_W-1:0] cnt_q, cnt_d;
    logic            filt_q, filt_d;

    always_comb begin
        filt_d = filt_q;
        cnt_d  = '0;
        if (raw != filt_q) begin
            // Counter saturating at all-ones marks the 2^DB_W-th differing sample.
            if (cnt_q == '1) begin
                filt_d = raw;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!clear_n) begin
            cnt_q  <= '0;
            filt_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            filt_q <= filt_d;
        end
    end

    assign filt = filt_q;

endmodule

// File: rtl/tick_sequencer.sv
// Enable/clear sequencer for a toggle-flop counter chain: free-run divider,
// single step and chain clear. Define STEP_DEBOUNCE_EN to debounce step/zero.
module tick_sequencer
    import tick_seq_pkg::*;
#(
    parameter int unsigned DIV_W     = 26,
    parameter int unsigned DIV_RESET = 49999999,
    parameter int unsigned DB_W      = 16
) (
    input  logic              clock,
    input  logic              clear_n,
    input  logic              run,
    input  logic              step,
    input  logic              zero,
    input  logic              div_load,
    input  logic [DIV_W-1:0]  div_value,
    output logic              enable,
    output logic              chain_clear,
    output logic [1:0]        state,
    output logic [TICK_W-1:0] tick_count
);

    logic step_f;
    logic zero_f;

`ifdef STEP_DEBOUNCE_EN
    debounce #(.DB_W(DB_W)) u_db_step (
        .clock   (clock),
        .clear_n (clear_n),
        .raw     (step),
        .filt    (step_f)
    );
    debounce #(.DB_W(DB_W)) u_db_zero (
        .clock   (clock),
        .clear_n (clear_n),
        .raw     (zero),
        .filt    (zero_f)
    );
`else
    assign step_f = step;
    assign zero_f = zero;
`endif

    state_t              state_q, state_d;
    logic [DIV_W-1:0]    cnt_q, cnt_d;
    logic [DIV_W-1:0]    div_reg_q, div_reg_d;
    logic                step_prev_q, step_prev_d;
    logic                zero_lock_q, zero_lock_d;
    logic [TICK_W-1:0]   tick_q, tick_d;
    logic                enable_c;
    logic                clear_c;
    logic                step_rise;
    logic                zero_req;

    assign step_rise = step_f && !step_prev_q;
    // zero_lock holds off re-entry to ZERO until zero has been seen low once.
    assign zero_req  = zero_f && !zero_lock_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = '0;
        div_reg_d   = div_reg_q;
        enable_c    = 1'b0;
        clear_c     = 1'b0;
        step_prev_d = step_f;
        zero_lock_d = (state_q == ZERO) ? zero_f : (zero_lock_q && zero_f);

        case (state_q)
            IDLE: begin
                if (zero_req)       state_d = ZERO;
                else if (run)       state_d = RUN;
                else if (step_rise) state_d = STEP;
            end
            RUN: begin
                if (zero_req) begin
                    state_d = ZERO;
                end else if (!run) begin
                    state_d = IDLE;
                end else if (cnt_q == div_reg_q) begin
                    enable_c = !div_load;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STEP: begin
                enable_c = 1'b1;
                state_d  = IDLE;
            end
            ZERO: begin
                clear_c = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (div_load) begin
            div_reg_d = div_value;
            cnt_d     = '0;
        end

        if (clear_c)       tick_d = '0;
        else if (enable_c) tick_d = tick_q + 1'b1;
        else               tick_d = tick_q;
    end

    always_ff @(posedge clock) begin
        if (!clear_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            div_reg_q   <= DIV_W'(DIV_RESET);
            step_prev_q <= 1'b0;
            zero_lock_q <= 1'b0;
            tick_q      <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            div_reg_q   <= div_reg_d;
            step_prev_q <= step_prev_d;
            zero_lock_q <= zero_lock_d;
            tick_q      <= tick_d;
        end
    end

    // Pulses are gated by clear_n so a reset edge never lets one escape.
    assign enable      = enable_c && clear_n;
    assign chain_clear = clear_c && clear_n;
    assign state       = state_q;
    assign tick_count  = tick_q;

endmodule
